// File: rtl/piece_motion_ctrl.sv
// piece_motion_ctrl: turns square-level piece commands into pixel offsets
// for one sprite renderer. MOVE slides toward the target once per frame,
// PLACE snaps, CAPTURE hides the sprite, NOP only acknowledges.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high
// ST_MOVE  | sliding toward target, one STEP per axis per frame_tick

module piece_motion_ctrl #(
   parameter int SQUARE    = 60,
   parameter int STEP      = 4,
   parameter int INIT_FILE = 0,
   parameter int INIT_RANK = 0
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_kind,
   input  logic [2:0] cmd_file,
   input  logic [2:0] cmd_rank,
   output logic [9:0] offsetX,
   output logic [9:0] offsetY,
   output logic       captured,
   output logic       moving,
   output logic       done
);

   localparam logic [9:0]        INIT_X  = 10'(INIT_FILE * SQUARE);
   localparam logic [9:0]        INIT_Y  = 10'(INIT_RANK * SQUARE);
   localparam logic [9:0]        STEP_PX = 10'(STEP);
   localparam logic signed [10:0] STEP_S = 11'(STEP);

   typedef enum logic [1:0] {
      KIND_MOVE    = 2'b00,
      KIND_PLACE   = 2'b01,
      KIND_CAPTURE = 2'b10,
      KIND_NOP     = 2'b11
   } kind_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MOVE = 1'b1
   } state_e;

   state_e     state_q;
   logic [9:0] off_x_q, off_y_q;
   logic [9:0] tgt_x_q, tgt_y_q;
   logic       captured_q;
   logic       done_q;

   logic [9:0] off_x_d, off_y_d;
   logic       arrive_d;

   function automatic logic [9:0] sq_to_px(input logic [2:0] idx);
      return 10'(idx) * 10'(SQUARE);
   endfunction

   // Clamp to the target when within one step so an axis never overshoots.
   function automatic logic [9:0] step_axis(input logic [9:0] cur, input logic [9:0] tgt);
      logic signed [10:0] diff;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      if ((diff <= STEP_S) && (diff >= -STEP_S)) return tgt;
      else if (diff > 11'sd0)                     return cur + STEP_PX;
      else                                        return cur - STEP_PX;
   endfunction

   // Candidate offsets for the next frame_tick and whether they land on target.
   always_comb begin
      off_x_d  = step_axis(off_x_q, tgt_x_q);
      off_y_d  = step_axis(off_y_q, tgt_y_q);
      arrive_d = (off_x_d == tgt_x_q) && (off_y_d == tgt_y_q);
   end

   // Command FSM with registered offsets, capture flag and done pulse.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         off_x_q    <= INIT_X;
         off_y_q    <= INIT_Y;
         tgt_x_q    <= INIT_X;
         tgt_y_q    <= INIT_Y;
         captured_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (kind_e'(cmd_kind))
                     KIND_MOVE: begin
                        tgt_x_q <= sq_to_px(cmd_file);
                        tgt_y_q <= sq_to_px(cmd_rank);
                        state_q <= ST_MOVE;
                     end
                     KIND_PLACE: begin
                        tgt_x_q    <= sq_to_px(cmd_file);
                        tgt_y_q    <= sq_to_px(cmd_rank);
                        off_x_q    <= sq_to_px(cmd_file);
                        off_y_q    <= sq_to_px(cmd_rank);
                        captured_q <= 1'b0;
                        done_q     <= 1'b1;
                     end
                     KIND_CAPTURE: begin
                        captured_q <= 1'b1;
                        done_q     <= 1'b1;
                     end
                     default: begin
                        done_q <= 1'b1;
                     end
                  endcase
               end
            end
            ST_MOVE: begin
               if (frame_tick) begin
                  off_x_q <= off_x_d;
                  off_y_q <= off_y_d;
                  if (arrive_d) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign moving    = (state_q == ST_MOVE);
   assign offsetX   = off_x_q;
   assign offsetY   = off_y_q;
   assign captured  = captured_q;
   assign done      = done_q;

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Directed bench for piece_motion_ctrl: instance A (STEP=4, start 4,6)
// covers straight/knight moves, held commands and async reset; instance B
// (STEP=7, start 0,0) covers clamping, capture, place and NOP.

module tb_piece_motion_ctrl;

   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b0;

   logic       a_ft = 1'b0, a_valid = 1'b0, a_ready, a_cap, a_mov, a_done;
   logic [1:0] a_kind = 2'd0;
   logic [2:0] a_file = 3'd0, a_rank = 3'd0;
   logic [9:0] a_x, a_y;

   logic       b_ft = 1'b0, b_valid = 1'b0, b_ready, b_cap, b_mov, b_done;
   logic [1:0] b_kind = 2'd0;
   logic [2:0] b_file = 3'd0, b_rank = 3'd0;
   logic [9:0] b_x, b_y;

   int n_cmp = 0;
   int n_err = 0;

   always #5 vga_clk = ~vga_clk;

   piece_motion_ctrl #(.SQUARE(60), .STEP(4), .INIT_FILE(4), .INIT_RANK(6)) u_a (
      .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(a_ft),
      .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_kind(a_kind),
      .cmd_file(a_file), .cmd_rank(a_rank), .offsetX(a_x), .offsetY(a_y),
      .captured(a_cap), .moving(a_mov), .done(a_done)
   );

   piece_motion_ctrl #(.SQUARE(60), .STEP(7), .INIT_FILE(0), .INIT_RANK(0)) u_b (
      .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(b_ft),
      .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_kind(b_kind),
      .cmd_file(b_file), .cmd_rank(b_rank), .offsetX(b_x), .offsetY(b_y),
      .captured(b_cap), .moving(b_mov), .done(b_done)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge vga_clk);
      #1;
   endtask

   initial begin
      // reset values while reset is held
      #12;
      check_eq("rst_hold_ax", a_x, 240);
      check_eq("rst_hold_ay", a_y, 360);
      check_eq("rst_hold_ardy", a_ready, 1);
      cyc();
      reset_n = 1'b1;
      cyc();
      check_eq("rst_ax", a_x, 240);
      check_eq("rst_ay", a_y, 360);
      check_eq("rst_acap", a_cap, 0);
      check_eq("rst_ardy", a_ready, 1);
      check_eq("rst_adone", a_done, 0);
      check_eq("rst_amov", a_mov, 0);
      check_eq("rst_bx", b_x, 0);
      check_eq("rst_by", b_y, 0);

      // A: MOVE (4,6)->(4,4); a second MOVE to (6,5) is held on the bus
      a_valid = 1'b1; a_kind = 2'b00; a_file = 3'd4; a_rank = 3'd4;
      cyc();
      check_eq("mv1_acc_mov", a_mov, 1);
      check_eq("mv1_acc_rdy", a_ready, 0);
      check_eq("mv1_acc_y", a_y, 360);
      a_file = 3'd6; a_rank = 3'd5;
      for (int k = 1; k <= 30; k++) begin
         a_ft = 1'b1; cyc(); a_ft = 1'b0;
         check_eq("mv1_y", a_y, 360 - 4 * k);
         check_eq("mv1_x", a_x, 240);
         check_eq("mv1_done", a_done, (k == 30) ? 1 : 0);
         check_eq("mv1_mov", a_mov, (k == 30) ? 0 : 1);
         if (k < 30) begin
            cyc();
            check_eq("mv1_hold_y", a_y, 360 - 4 * k);
            check_eq("mv1_hold_rdy", a_ready, 0);
         end
      end
      check_eq("mv1_done_rdy", a_ready, 1);
      // held command is accepted on the done-cycle edge
      cyc();
      a_valid = 1'b0;
      check_eq("mv2_acc_mov", a_mov, 1);
      check_eq("mv2_acc_done", a_done, 0);
      check_eq("mv2_acc_x", a_x, 240);
      check_eq("mv2_acc_y", a_y, 240);

      // A: knight move (4,4)->(6,5)
      for (int k = 1; k <= 30; k++) begin
         a_ft = 1'b1; cyc(); a_ft = 1'b0;
         check_eq("knt_x", a_x, 240 + 4 * k);
         check_eq("knt_y", a_y, (240 + 4 * k > 300) ? 300 : 240 + 4 * k);
         check_eq("knt_done", a_done, (k == 30) ? 1 : 0);
         if (k < 30) cyc();
      end
      cyc();
      check_eq("knt_done_clr", a_done, 0);
      check_eq("knt_rdy", a_ready, 1);

      // A: reset in the middle of a move toward (0,0)
      a_valid = 1'b1; a_kind = 2'b00; a_file = 3'd0; a_rank = 3'd0;
      cyc();
      a_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         a_ft = 1'b1; cyc(); a_ft = 1'b0;
      end
      check_eq("mid_x", a_x, 348);
      check_eq("mid_y", a_y, 288);
      #2 reset_n = 1'b0;
      #1;
      check_eq("arst_x", a_x, 240);
      check_eq("arst_y", a_y, 360);
      check_eq("arst_done", a_done, 0);
      check_eq("arst_mov", a_mov, 0);
      check_eq("arst_rdy", a_ready, 1);
      cyc();
      reset_n = 1'b1;
      cyc();
      a_ft = 1'b1; cyc(); a_ft = 1'b0;
      check_eq("arst_discard_x", a_x, 240);
      check_eq("arst_discard_mov", a_mov, 0);

      // B: frame_tick in IDLE does nothing
      b_ft = 1'b1; cyc(); b_ft = 1'b0;
      check_eq("idle_tick_x", b_x, 0);
      check_eq("idle_tick_done", b_done, 0);

      // B: NOP
      b_valid = 1'b1; b_kind = 2'b11; b_file = 3'd5; b_rank = 3'd5;
      cyc();
      b_valid = 1'b0;
      check_eq("nop_done", b_done, 1);
      check_eq("nop_x", b_x, 0);
      check_eq("nop_cap", b_cap, 0);
      cyc();
      check_eq("nop_done_clr", b_done, 0);

      // B: CAPTURE
      b_valid = 1'b1; b_kind = 2'b10;
      cyc();
      b_valid = 1'b0;
      check_eq("cap_cap", b_cap, 1);
      check_eq("cap_done", b_done, 1);
      check_eq("cap_x", b_x, 0);
      check_eq("cap_y", b_y, 0);

      // B: MOVE (0,0)->(1,0) with frame_tick coincident with accept
      b_valid = 1'b1; b_kind = 2'b00; b_file = 3'd1; b_rank = 3'd0; b_ft = 1'b1;
      cyc();
      b_valid = 1'b0; b_ft = 1'b0;
      check_eq("s7_acc_x", b_x, 0);
      check_eq("s7_acc_mov", b_mov, 1);
      for (int k = 1; k <= 9; k++) begin
         b_ft = 1'b1; cyc(); b_ft = 1'b0;
         check_eq("s7_x", b_x, (7 * k > 60) ? 60 : 7 * k);
         check_eq("s7_y", b_y, 0);
         check_eq("s7_cap", b_cap, 1);
         check_eq("s7_done", b_done, (k == 9) ? 1 : 0);
         if (k < 9) cyc();
      end

      // B: PLACE (2,3)
      b_valid = 1'b1; b_kind = 2'b01; b_file = 3'd2; b_rank = 3'd3;
      cyc();
      b_valid = 1'b0;
      check_eq("plc_x", b_x, 120);
      check_eq("plc_y", b_y, 180);
      check_eq("plc_cap", b_cap, 0);
      check_eq("plc_done", b_done, 1);
      check_eq("plc_mov", b_mov, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
